// File: rtl/brr_pkg.sv
// Shared types and helpers for the bus read-return path.
package brr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } brr_state_e;

    // Fill bit for rsp_data on any error response.
    localparam bit BRR_ERR_FILL = 1'b0;

    function automatic logic brr_sel_ok(input int unsigned sel, input int unsigned nch);
        return sel < nch;
    endfunction

endpackage

// File: rtl/brr_timeout_ctr.sv
// WAIT-phase timeout counter for bus_read_return (built only with BRR_TIMEOUT_EN).
module brr_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count holds the number of completed WAIT cycles, so this flags the
    // last permitted WAIT cycle and stays set until cleared.
    assign expired = (cnt_q >= LIMIT - 1'b1);

endmodule

// File: rtl/bus_read_return.sv
// Single-outstanding read-data return path: select slave, wait for rvalid, hold response.
// Optional WAIT timeout is built when BRR_TIMEOUT_EN is defined.
module bus_read_return
    import brr_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NCH         = 5,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SEL_W-1:0]     req_sel,
    input  logic [NCH-1:0]       slv_rvalid,
    input  logic [NCH*WIDTH-1:0] slv_rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err
);

    brr_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0] sel_rdata;
    logic             sel_rvalid;
    logic             tmo_expired;

    // Mux by compare rather than direct index so sel_q never addresses past NCH.
    always_comb begin
        sel_rdata  = '0;
        sel_rvalid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_rdata  = slv_rdata[i*WIDTH +: WIDTH];
                sel_rvalid = slv_rvalid[i];
            end
        end
    end

`ifdef BRR_TIMEOUT_EN
    brr_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == IDLE),
        .en      (state_q == WAIT),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (brr_sel_ok(32'(req_sel), NCH)) begin
                        sel_d   = req_sel;
                        state_d = WAIT;
                    end else begin
                        rsp_data_d = {WIDTH{BRR_ERR_FILL}};
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            WAIT: begin
                // Data takes priority over a timeout expiring in the same cycle.
                if (sel_rvalid) begin
                    rsp_data_d = sel_rdata;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (tmo_expired) begin
                    rsp_data_d = {WIDTH{BRR_ERR_FILL}};
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_read_return.sv
// Randomized + directed bench for bus_read_return against a transaction-level latency/result model.
module tb_bus_read_return;

    localparam int WIDTH = 32;
    localparam int NCH   = 5;
    localparam int SEL_W = 3;
    localparam int TMO   = 16;
`ifdef BRR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [SEL_W-1:0]     req_sel;
    logic [NCH-1:0]       slv_rvalid;
    logic [NCH*WIDTH-1:0] slv_rdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH-1:0]     rsp_data;
    logic                 rsp_err;

    int n_vec = 0;
    int n_err = 0;

    bus_read_return #(
        .WIDTH       (WIDTH),
        .NCH         (NCH),
        .SEL_W       (SEL_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .slv_rvalid (slv_rvalid),
        .slv_rdata  (slv_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic randomize_bus(input int keep_off);
        for (int c = 0; c < NCH; c++) begin
            slv_rdata[c*WIDTH +: WIDTH] = $urandom;
        end
        slv_rvalid = NCH'($urandom);
        if (keep_off >= 0 && keep_off < NCH) slv_rvalid[keep_off] = 1'b0;
    endtask

    // One read: sel target, rvalid on the dly-th WAIT cycle (0 = first), bp cycles of backpressure.
    task automatic do_read(input int sel, input int dly, input int bp, input logic [31:0] dat);
        int          lat;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_data;
        if (sel >= NCH) begin
            exp_lat = 1; exp_err = 1'b1; exp_data = '0;
        end else if (TMO_EN && dly >= TMO) begin
            exp_lat = TMO + 1; exp_err = 1'b1; exp_data = '0;
        end else begin
            exp_lat = dly + 2; exp_err = 1'b0; exp_data = dat;
        end

        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_sel   = SEL_W'(sel);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            randomize_bus(sel);
            if (sel < NCH && lat - 1 == dly) begin
                slv_rvalid[sel]            = 1'b1;
                slv_rdata[sel*WIDTH +: 32] = dat;
            end
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});

        // Strobes on any channel during RESP must not disturb the held response.
        for (int b = 0; b < bp; b++) begin
            randomize_bus(-1);
            tick();
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_data", rsp_data, exp_data);
            chk("bp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        end

        // Handshake cycle: a concurrent request must not be taken.
        rsp_ready = 1'b1;
        req_valid = 1'($urandom);
        req_sel   = SEL_W'($urandom_range(0, NCH - 1));
        tick();
        rsp_ready  = 1'b0;
        req_valid  = 1'b0;
        slv_rvalid = '0;
        chk("post_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_ready", {31'b0, req_ready}, 32'd1);
        chk("post_data", rsp_data, exp_data);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_sel    = '0;
        slv_rvalid = '0;
        slv_rdata  = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic read, wrong-channel strobe, bad select, backpressure.
        do_read(2, 0, 0, 32'hDEADBEEF);
        do_read(4, 3, 0, 32'h0000CAFE);
        do_read(6, 0, 0, 32'h12345678);
        do_read(1, 1, 5, 32'hA5A5A5A5);

        // Timeout / no-timeout behaviour on an unanswered read.
`ifdef BRR_TIMEOUT_EN
        do_read(0, 1000, 0, 32'h0);
`else
        req_valid = 1'b1;
        req_sel   = '0;
        tick();
        req_valid = 1'b0;
        repeat (99) begin
            randomize_bus(0);
            tick();
        end
        slv_rvalid = '0;
        chk("still_wait_ready", {31'b0, req_ready}, 32'd0);
        chk("still_wait_valid", {31'b0, rsp_valid}, 32'd0);
        slv_rvalid[0]        = 1'b1;
        slv_rdata[0 +: 32]   = 32'h0BADF00D;
        tick();
        slv_rvalid = '0;
        chk("late_wait_data", rsp_data, 32'h0BADF00D);
        chk("late_wait_err", {31'b0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
        // Strobe while IDLE is discarded.
        slv_rvalid = '1;
        tick();
        slv_rvalid = '0;
        chk("idle_strobe_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_strobe_ready", {31'b0, req_ready}, 32'd1);

        // Reset mid-WAIT.
        req_valid = 1'b1;
        req_sel   = 3'd1;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        chk("pre_rst_ready", {31'b0, req_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        slv_rvalid[1] = 1'b1;
        tick();
        slv_rvalid = '0;
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
        do_read(1, 2, 0, 32'h600DCAFE);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            int s, d, b;
            s = $urandom_range(0, 7);
            d = TMO_EN ? $urandom_range(0, 20) : $urandom_range(0, 12);
            b = $urandom_range(0, 3);
            do_read(s, d, b, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
